// File: rtl/vend_arbiter.sv
// Two-slot coin arbiter: per-slot coin FIFOs, round-robin pop into a 0..3 credit, vend handshake.
// Coin-to-credit latency 2 cycles; full FIFOs reject; optional watchdog via VEND_ARBITER_WATCHDOG_EN.
module vend_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_dat,
  input  logic       pop,
  output logic [1:0] pop_dat,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    rd_en    = pop && !empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_en    = push && (!full || rd_en);
    pop_dat  = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

module vend_arbiter #(
  parameter int         FIFO_DEPTH = 2,
  parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coinA,
  input  logic [1:0] coinB,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic [3:0] credit,
  output logic       rejectA,
  output logic       rejectB,
  output logic       busy
`ifdef VEND_ARBITER_WATCHDOG_EN
  , output logic     fault
`endif
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEND = 2'd1
`ifdef VEND_ARBITER_WATCHDOG_EN
    , ST_FAULT = 2'd2
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_b_q, ptr_b_d;
  logic [3:0] credit_q, credit_d;
  logic       vend_req_q, vend_req_d;
  logic       rej_a_q, rej_a_d, rej_b_q, rej_b_d;
  logic       a_empty, a_full, b_empty, b_full, pop_a, pop_b;
  logic [1:0] a_dat, b_dat;
  logic [3:0] coin_val, sum;
`ifdef VEND_ARBITER_WATCHDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       fault_q, fault_d;
`else
  logic       unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
`endif

  vend_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock(clock), .reset(reset), .push(coinA != 2'b00), .push_dat(coinA),
    .pop(pop_a), .pop_dat(a_dat), .empty(a_empty), .full(a_full)
  );
  vend_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock(clock), .reset(reset), .push(coinB != 2'b00), .push_dat(coinB),
    .pop(pop_b), .pop_dat(b_dat), .empty(b_empty), .full(b_full)
  );

  always_comb begin
    state_d  = state_q;
    ptr_b_d  = ptr_b_q;
    credit_d = credit_q;
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    coin_val = 4'd0;
    sum      = 4'd0;
`ifdef VEND_ARBITER_WATCHDOG_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // ptr_b_q set means slot B has priority when both hold coins.
        if (!a_empty && (b_empty || !ptr_b_q)) pop_a = 1'b1;
        else if (!b_empty)                     pop_b = 1'b1;
        case (pop_b ? b_dat : a_dat)
          2'b01:   coin_val = 4'd1;
          2'b10:   coin_val = 4'd3;
          2'b11:   coin_val = 4'd5;
          default: coin_val = 4'd0;
        endcase
        sum = credit_q + coin_val;
        if (pop_a || pop_b) begin
          ptr_b_d = pop_a;
          if (sum < 4'd4) begin
            credit_d = sum;
          end else begin
            credit_d = (sum > 4'd7) ? 4'd3 : sum - 4'd4;
            state_d  = ST_VEND;
`ifdef VEND_ARBITER_WATCHDOG_EN
            wdog_d   = 8'd0;
`endif
          end
        end
      end
      ST_VEND: begin
        if (vend_ack) state_d = ST_IDLE;
`ifdef VEND_ARBITER_WATCHDOG_EN
        else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == WDOG_LIMIT) state_d = ST_FAULT;
        end
`endif
      end
      default: state_d = state_q;
    endcase
    rej_a_d    = (coinA != 2'b00) && a_full && !pop_a;
    rej_b_d    = (coinB != 2'b00) && b_full && !pop_b;
    vend_req_d = (state_d == ST_VEND);
`ifdef VEND_ARBITER_WATCHDOG_EN
    fault_d    = (state_d == ST_FAULT);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_b_q    <= 1'b0;
      credit_q   <= 4'd0;
      vend_req_q <= 1'b0;
      rej_a_q    <= 1'b0;
      rej_b_q    <= 1'b0;
`ifdef VEND_ARBITER_WATCHDOG_EN
      wdog_q     <= 8'd0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_b_q    <= ptr_b_d;
      credit_q   <= credit_d;
      vend_req_q <= vend_req_d;
      rej_a_q    <= rej_a_d;
      rej_b_q    <= rej_b_d;
`ifdef VEND_ARBITER_WATCHDOG_EN
      wdog_q     <= wdog_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign vend_req = vend_req_q;
  assign credit   = credit_q;
  assign rejectA  = rej_a_q;
  assign rejectB  = rej_b_q;
  assign busy     = (state_q != ST_IDLE) || !a_empty || !b_empty;
`ifdef VEND_ARBITER_WATCHDOG_EN
  assign fault    = fault_q;
`endif
endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, per-slot coin buffer depth; legal values are 2 and 4.
REQ-002 Parameter WDOG_LIMIT, default 255, number of VEND cycles without vend_ack before fault; width 8.
REQ-003 Port clock  input  1  single clock; all state changes on posedge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port coinA  input  2  slot A coin code: 00 none, 01 = 1 credit, 10 = 3 credits, 11 = 5 credits.
REQ-006 Port coinB  input  2  slot B coin code, same encoding as coinA.
REQ-007 Port vend_ack  input  1  dispenser done; sampled only in VEND.
REQ-008 Port vend_req  output  1  dispense request (level), registered.
REQ-009 Port credit  output  4  current credit 0..3, registered; bits [3:2] always 0.
REQ-010 Port rejectA, rejectB  output  1 each  one-cycle pulse: coin on that slot not buffered, to be returned.
REQ-011 Port busy  output  1  high when state is not IDLE or either FIFO is non-empty.
REQ-012 Port fault  output  1  watchdog fault flag; present only with WATCHDOG_EN.

Function
REQ-013 Each slot SHALL own a FIFO of FIFO_DEPTH entries; a non-00 code in cycle t is written at end of t.
REQ-014 A write to a full FIFO SHALL be dropped and the slot's reject SHALL pulse in cycle t+1; a write to a full FIFO being popped in the same cycle SHALL be accepted.
REQ-015 States: IDLE, VEND, and FAULT (FAULT only with WATCHDOG_EN).
REQ-016 In IDLE, at most one coin per cycle SHALL be popped, chosen round-robin.
REQ-017 Round-robin rule: if both FIFOs are non-empty, pop the slot not granted last; if only one is non-empty, pop it; the pointer updates only on a pop.
REQ-018 On a pop, sum = credit + coin value (1/3/5), computed 4 bits wide.
REQ-019 If sum < 4: credit <= sum; remain in IDLE.
REQ-020 If sum >= 4: credit <= min(sum-4, 3), with excess forfeited; go to VEND; vend_req = 1 from the next cycle.
REQ-021 Latency: a coin presented in cycle t into an empty FIFO with the pointer favouring it SHALL update credit and vend_req visibly in cycle t+2.
REQ-022 In VEND, no pops SHALL occur; FIFOs SHALL keep accepting and rejecting per REQ-014.
REQ-023 In VEND, vend_ack = 1 SHALL return the FSM to IDLE; vend_req = 0 the next cycle; a pop is allowed in the cycle after return.
REQ-024 vend_ack outside VEND SHALL be ignored.
REQ-025 Simultaneous coins on both slots in the same cycle SHALL both be buffered if space exists; neither is lost or merged.

Reset
REQ-026 Reset SHALL force: state IDLE, both FIFOs empty, RR pointer to slot A, credit 0, vend_req 0, rejectA/B 0, busy 0, fault 0.
REQ-027 Reset SHALL take priority over all inputs, including mid-VEND and mid-FAULT.
REQ-028 Buffered coins and credit are discarded on reset, with no reject pulses.

Configuration
REQ-029 Macro VEND_ARBITER_WATCHDOG_EN: when defined, an 8-bit counter clears on entry to VEND and increments each VEND cycle without vend_ack.
REQ-030 With the macro defined, reaching WDOG_LIMIT SHALL enter FAULT: vend_req 0, fault 1, no pops, coins still buffered or rejected; FAULT exits only by reset.
REQ-031 Without the macro: no counter, no FAULT state, fault port absent; VEND waits indefinitely.

Verification
REQ-032 Reset, then coinA=01 for one cycle -> credit=1 two cycles later, vend_req 0, busy then 0.
REQ-033 coinA=10 and coinB=10 in the same cycle with pointer at A -> A popped first (credit 3), then B (sum 6): vend_req=1, credit=2; vend_ack -> vend_req 0, then IDLE.
REQ-034 credit=3, then coinA=11 -> vend_req=1, credit=3 (8-4 capped at 3).
REQ-035 Hold VEND without ack, insert 3 coins on slot B with FIFO_DEPTH=2 -> third coin gives a rejectB pulse; after ack, the 2 buffered coins are consumed in consecutive cycles.
REQ-036 WATCHDOG_EN defined, VEND held 255 cycles without ack -> fault=1, vend_req=0; reset -> fault=0, credit=0.
REQ-037 Reset asserted in VEND with both FIFOs full -> all outputs at REQ-026 values the next cycle.
